// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_OBS_IDX = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, clear handshake, debug tap.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;
  logic [DATA_W-1:0]        obs_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, clr_busy, clr_done, obs_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, clr_busy, clr_done, obs_data
  );
endinterface

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks the array one entry per cycle (IDLE -> CLEAR x DEPTH -> DONE -> IDLE).
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // Hold at the last index rather than wrapping; DONE is the exit.
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        clr_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational reads, one synchronous write, bulk clear, obs tap.
// Define REGFILE_BYPASS_EN to forward a committing write to same-address readers in the same cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int OBS_IDX  = DEF_OBS_IDX
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] OBS_A = ADDR_W'(OBS_IDX);

  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_vals;
  logic                          clr_busy, clr_done, clr_we;
  logic [ADDR_W-1:0]             clr_addr;
  logic                          zero_wr, wr_commit;

  regfile_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign zero_wr   = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign wr_commit = bus.wr_en && !clr_busy && !zero_wr;

  always_comb begin
    mem_d = mem_q;
    if (clr_we)         mem_d[clr_addr]    = '0;
    else if (wr_commit) mem_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero_hit, byp_hit;
    assign a        = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (a == '0);
`ifdef REGFILE_BYPASS_EN
    assign byp_hit  = wr_commit && (a == bus.wr_addr);
`else
    assign byp_hit  = 1'b0;
`endif
    assign rd_vals[i] = byp_hit ? bus.wr_data : (zero_hit ? '0 : mem_q[a]);
  end

  logic obs_zero, obs_byp;
  assign obs_zero = (ZERO_REG != 0) && (OBS_A == '0);
`ifdef REGFILE_BYPASS_EN
  assign obs_byp  = wr_commit && (bus.wr_addr == OBS_A);
`else
  assign obs_byp  = 1'b0;
`endif

  assign bus.obs_data = obs_byp ? bus.wr_data : (obs_zero ? '0 : mem_q[OBS_A]);
  assign bus.rd_data  = rd_vals;
  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule
